// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared types and constants for the FIR APB control block.
// Contents: launch FSM state encoding, register byte offsets, CTRL/STATUS bit indices.
// Optional FIR_TIMEOUT_EN only adds the TMO_LIMIT register at OFF_TMO_LIMIT.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ACK = 2'd2,
    RUN      = 2'd3
  } state_t;

  // Register byte offsets (word aligned)
  localparam logic [7:0] OFF_CTRL        = 8'h00;
  localparam logic [7:0] OFF_STATUS      = 8'h04;
  localparam logic [7:0] OFF_NUM_TAPS    = 8'h08;
  localparam logic [7:0] OFF_NUM_SAMPLES = 8'h0C;
  localparam logic [7:0] OFF_TMO_LIMIT   = 8'h10;

  // CTRL bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  // STATUS bits
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_TIMEOUT = 3;

endpackage

// File: rtl/fir_apb_regs.sv
// fir_apb_regs: APB decode, configuration/status storage, registered prdata, pslverr.
// Ports: APB slave signals in; busy and flag-set strobes from the launch FSM in;
//        start_wr strobe, tap/sample counts, irq (and tmo_limit with FIR_TIMEOUT_EN) out.
module fir_apb_regs
  import fir_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
`ifdef FIR_TIMEOUT_EN
  parameter int TMO_W  = 24,
`endif
  parameter int TAP_W  = 8,
  parameter int SMP_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pslverr,
  input  logic              busy,
  input  logic              done_set,
  input  logic              err_set,
`ifdef FIR_TIMEOUT_EN
  input  logic              tmo_set,
  output logic [TMO_W-1:0]  tmo_limit,
`endif
  output logic              start_wr,
  output logic [TAP_W-1:0]  liczba_wsp,
  output logic [SMP_W-1:0]  liczba_probek,
  output logic              irq
);

  logic        setup, access;
  logic        sel_ctrl, sel_status, sel_taps, sel_smp, sel_tmo;
  logic        mapped, cfg_sel, cfg_locked, wr_ok;
  logic        irq_en, done_flag, err_flag, tmo_flag;
  logic [31:0] w1c, rdata;
  logic        unused_pwdata;

  assign setup  = psel & ~penable;
  assign access = psel &  penable;

  assign sel_ctrl   = (paddr == ADDR_W'(OFF_CTRL));
  assign sel_status = (paddr == ADDR_W'(OFF_STATUS));
  assign sel_taps   = (paddr == ADDR_W'(OFF_NUM_TAPS));
  assign sel_smp    = (paddr == ADDR_W'(OFF_NUM_SAMPLES));
`ifdef FIR_TIMEOUT_EN
  assign sel_tmo    = (paddr == ADDR_W'(OFF_TMO_LIMIT));
`else
  assign sel_tmo    = 1'b0;
`endif

  assign mapped     = sel_ctrl | sel_status | sel_taps | sel_smp | sel_tmo;
  assign cfg_sel    = sel_taps | sel_smp | sel_tmo;
  // Configuration is frozen while a job runs so the engine sees stable counts.
  assign cfg_locked = pwrite & cfg_sel & busy;
  assign pslverr    = access & (~mapped | cfg_locked);
  assign wr_ok      = access & pwrite & mapped & ~cfg_locked;
  assign start_wr   = wr_ok & sel_ctrl & pwdata[CTRL_START];
  assign w1c        = (wr_ok & sel_status) ? pwdata : 32'd0;

  // Upper write-data bits have no register behind them.
  assign unused_pwdata = ^pwdata;

  assign irq = irq_en & (done_flag | err_flag | tmo_flag);

  always_comb begin
    rdata = 32'd0;
    if (sel_ctrl) rdata[CTRL_IRQ_EN] = irq_en;
    if (sel_status) begin
      rdata[ST_BUSY]    = busy;
      rdata[ST_DONE]    = done_flag;
      rdata[ST_ERR]     = err_flag;
      rdata[ST_TIMEOUT] = tmo_flag;
    end
    if (sel_taps) rdata[TAP_W-1:0] = liczba_wsp;
    if (sel_smp)  rdata[SMP_W-1:0] = liczba_probek;
`ifdef FIR_TIMEOUT_EN
    if (sel_tmo)  rdata[TMO_W-1:0] = tmo_limit;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prdata        <= 32'd0;
      irq_en        <= 1'b0;
      liczba_wsp    <= TAP_W'(1);
      liczba_probek <= SMP_W'(1);
      done_flag     <= 1'b0;
      err_flag      <= 1'b0;
    end else begin
      // Read data captured in the setup phase, presented in the access phase.
      if (setup) prdata <= rdata;
      if (wr_ok & sel_ctrl) irq_en        <= pwdata[CTRL_IRQ_EN];
      if (wr_ok & sel_taps) liczba_wsp    <= pwdata[TAP_W-1:0];
      if (wr_ok & sel_smp)  liczba_probek <= pwdata[SMP_W-1:0];
      // Hardware set takes priority over a same-cycle software clear.
      done_flag <= done_set | (done_flag & ~w1c[ST_DONE]);
      err_flag  <= err_set  | (err_flag  & ~w1c[ST_ERR]);
    end
  end

`ifdef FIR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_limit <= '1;
      tmo_flag  <= 1'b0;
    end else begin
      if (wr_ok & sel_tmo) tmo_limit <= pwdata[TMO_W-1:0];
      tmo_flag <= tmo_set | (tmo_flag & ~w1c[ST_TIMEOUT]);
    end
  end
`else
  assign tmo_flag = 1'b0;
`endif

endmodule

// File: rtl/fir_apb_ctrl.sv
// fir_apb_ctrl: APB control/status front end for the FIR engine (launch FSM + regs).
// Ports: APB slave (zero wait), START/FSM_abort pulses and tap/sample counts to the
//        FIR FSM, pracuje/DONE from it, level irq. Macro FIR_TIMEOUT_EN adds a job timeout.
module fir_apb_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int TAP_W  = 8,
  parameter int SMP_W  = 16,
  parameter int TMO_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              START,
  input  logic              pracuje,
  input  logic              DONE,
  output logic [TAP_W-1:0]  liczba_wsp,
  output logic [SMP_W-1:0]  liczba_probek,
  output logic              FSM_abort,
  output logic              irq
);

  state_t state, state_nxt;
  logic   busy, start_wr, counts_ok, active, done_set, err_set, tmo_hit;

  assign pready    = 1'b1;
  assign counts_ok = (|liczba_wsp) & (|liczba_probek);
  assign active    = (state == WAIT_ACK) | (state == RUN);

`ifdef FIR_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_limit, tmo_cnt;

  // Counts job cycles from WAIT_ACK entry; zero limit disables the timeout.
  always_ff @(posedge clk) begin
    if (rst)                  tmo_cnt <= '0;
    else if (state == LAUNCH) tmo_cnt <= '0;
    else if (active)          tmo_cnt <= tmo_cnt + 1'b1;
  end

  // A DONE in the same cycle beats the timeout.
  assign tmo_hit = active & (tmo_limit != '0) & (tmo_cnt == tmo_limit) & ~DONE;
`else
  logic [TMO_W-1:0] unused_tmo_w;
  assign unused_tmo_w = '0;
  assign tmo_hit      = 1'b0;
`endif

  fir_apb_regs #(
    .ADDR_W (ADDR_W),
`ifdef FIR_TIMEOUT_EN
    .TMO_W  (TMO_W),
`endif
    .TAP_W  (TAP_W),
    .SMP_W  (SMP_W)
  ) u_regs (
    .clk           (clk),
    .rst           (rst),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pslverr       (pslverr),
    .busy          (busy),
    .done_set      (done_set),
    .err_set       (err_set),
`ifdef FIR_TIMEOUT_EN
    .tmo_set       (tmo_hit),
    .tmo_limit     (tmo_limit),
`endif
    .start_wr      (start_wr),
    .liczba_wsp    (liczba_wsp),
    .liczba_probek (liczba_probek),
    .irq           (irq)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_wr && counts_ok) state_nxt = LAUNCH;
      LAUNCH:   state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        // DONE before pracuje covers jobs shorter than the ack latency.
        if (DONE || tmo_hit) state_nxt = IDLE;
        else if (pracuje)    state_nxt = RUN;
      end
      RUN:      if (DONE || tmo_hit) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    START     = (state == LAUNCH);
    busy      = (state != IDLE);
    done_set  = active & DONE;
    err_set   = start_wr & ((state != IDLE) | ~counts_ok);
    FSM_abort = tmo_hit;
  end

endmodule

// File: tb/tb_fir_apb_ctrl.sv
module tb_fir_apb_ctrl;

  logic        clk = 1'b0;
  logic        rst, psel, penable, pwrite, pracuje, DONE;
  logic [4:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, START, FSM_abort, irq;
  logic [7:0]  liczba_wsp;
  logic [15:0] liczba_probek;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int abort_cnt = 0;

  fir_apb_ctrl dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .START(START), .pracuje(pracuje), .DONE(DONE),
    .liczba_wsp(liczba_wsp), .liczba_probek(liczba_probek),
    .FSM_abort(FSM_abort), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (START)     start_cnt++;
    if (FSM_abort) abort_cnt++;
  end

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic apb_wr(input logic [4:0] a, input logic [31:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [4:0] a, output logic [31:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic        e;
    logic [31:0] d;
    int          sc;

    //           wr    addr   wdata         rdata         err
    tbl[0]  = '{1'b0, 5'h00, 32'h0,        32'h0,        1'b0};
    tbl[1]  = '{1'b0, 5'h04, 32'h0,        32'h0,        1'b0};
    tbl[2]  = '{1'b0, 5'h08, 32'h0,        32'h1,        1'b0};
    tbl[3]  = '{1'b0, 5'h0C, 32'h0,        32'h1,        1'b0};
`ifdef FIR_TIMEOUT_EN
    tbl[4]  = '{1'b0, 5'h10, 32'h0,        32'h00FFFFFF, 1'b0};
`else
    tbl[4]  = '{1'b0, 5'h10, 32'h0,        32'h0,        1'b1};
`endif
    tbl[5]  = '{1'b0, 5'h14, 32'h0,        32'h0,        1'b1};
    tbl[6]  = '{1'b0, 5'h1C, 32'h0,        32'h0,        1'b1};
    tbl[7]  = '{1'b0, 5'h02, 32'h0,        32'h0,        1'b1};
    tbl[8]  = '{1'b1, 5'h08, 32'h8,        32'h0,        1'b0};
    tbl[9]  = '{1'b1, 5'h0C, 32'h4,        32'h0,        1'b0};
    tbl[10] = '{1'b0, 5'h08, 32'h0,        32'h8,        1'b0};
    tbl[11] = '{1'b0, 5'h0C, 32'h0,        32'h4,        1'b0};
    tbl[12] = '{1'b1, 5'h00, 32'h2,        32'h0,        1'b0};
    tbl[13] = '{1'b0, 5'h00, 32'h0,        32'h2,        1'b0};
    tbl[14] = '{1'b1, 5'h14, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[15] = '{1'b1, 5'h0C, 32'h00012345, 32'h0,        1'b0};
    tbl[16] = '{1'b0, 5'h0C, 32'h0,        32'h2345,     1'b0};
    tbl[17] = '{1'b1, 5'h0C, 32'h4,        32'h0,        1'b0};
    tbl[18] = '{1'b0, 5'h00, 32'h0,        32'h2,        1'b0};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pracuje = 1'b0; DONE = 1'b0;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_start",   32'(START), 32'h0);
    chk("rst_pready",  32'(pready), 32'h1);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_irq",     32'(irq), 32'h0);
    chk("rst_abort",   32'(FSM_abort), 32'h0);
    chk("rst_prdata",  prdata, 32'h0);
    chk("rst_taps",    32'(liczba_wsp), 32'h1);
    chk("rst_smp",     32'(liczba_probek), 32'h1);
    cyc(1);

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].wr) begin
        apb_wr(tbl[i].addr, tbl[i].wdata, e);
        chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].err));
      end else begin
        apb_rd(tbl[i].addr, d, e);
        chk($sformatf("vec%0d_data", i), d, tbl[i].rdata);
        chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].err));
      end
    end

    // Launch: write access cycle T, START only in T+1.
    sc = start_cnt;
    apb_wr(5'h00, 32'h3, e);
    @(negedge clk);
    chk("launch_start_t1", 32'(START), 32'h1);
    cyc(1);
    @(negedge clk);
    chk("launch_start_t2", 32'(START), 32'h0);
    cyc(1);                                     // T+3
    pracuje = 1'b1;
    apb_rd(5'h04, d, e);                        // returns at T+5
    chk("run_status", d, 32'h1);
    cyc(15);                                    // T+20
    DONE = 1'b1;
    cyc(1);                                     // T+21
    DONE = 1'b0; pracuje = 1'b0;
    @(negedge clk);
    chk("done_irq", 32'(irq), 32'h1);
    chk("one_start", 32'(start_cnt - sc), 32'h1);
    apb_rd(5'h04, d, e);
    chk("done_status", d, 32'h2);
    apb_wr(5'h04, 32'h2, e);
    @(negedge clk);
    chk("w1c_irq", 32'(irq), 32'h0);
    cyc(1);

    // START while running, and config write while busy.
    apb_wr(5'h00, 32'h3, e);
    cyc(1);
    pracuje = 1'b1;
    cyc(1);
    sc = start_cnt;
    apb_wr(5'h00, 32'h3, e);
    chk("restart_err", 32'(e), 32'h0);
    cyc(3);
    chk("restart_no_pulse", 32'(start_cnt), 32'(sc));
    apb_rd(5'h04, d, e);
    chk("restart_status", d, 32'h5);
    apb_wr(5'h08, 32'h5, e);
    chk("busy_cfg_err", 32'(e), 32'h1);
    chk("busy_cfg_taps", 32'(liczba_wsp), 32'h8);
    DONE = 1'b1;
    cyc(1);
    DONE = 1'b0; pracuje = 1'b0;
    apb_rd(5'h04, d, e);
    chk("end2_status", d, 32'h6);
    chk("end2_irq", 32'(irq), 32'h1);
    apb_wr(5'h04, 32'h6, e);
    apb_rd(5'h04, d, e);
    chk("clear_status", d, 32'h0);

    // Zero tap count: START refused with ERR.
    apb_wr(5'h08, 32'h0, e);
    sc = start_cnt;
    apb_wr(5'h00, 32'h1, e);
    cyc(3);
    chk("zero_no_pulse", 32'(start_cnt), 32'(sc));
    apb_rd(5'h04, d, e);
    chk("zero_status", d, 32'h4);
    apb_rd(5'h14, d, e);
    chk("unmapped_err", 32'(e), 32'h1);
    chk("unmapped_data", d, 32'h0);
    apb_wr(5'h08, 32'h8, e);
    apb_wr(5'h04, 32'h4, e);

    // W1C of DONE in the very cycle DONE is raised: the set wins.
    apb_wr(5'h00, 32'h1, e);
    pracuje = 1'b1;
    cyc(3);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h04; pwdata = 32'h2;
    cyc(1);
    penable = 1'b1; DONE = 1'b1;
    cyc(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; DONE = 1'b0; pracuje = 1'b0;
    apb_rd(5'h04, d, e);
    chk("w1c_race_status", d, 32'h2);
    apb_wr(5'h04, 32'h2, e);

    // Reset in the middle of a job.
    apb_wr(5'h00, 32'h1, e);
    pracuje = 1'b1;
    cyc(3);
    sc = start_cnt;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; pracuje = 1'b0;
    @(negedge clk);
    chk("midrst_taps", 32'(liczba_wsp), 32'h1);
    chk("midrst_smp", 32'(liczba_probek), 32'h1);
    chk("midrst_start", 32'(START), 32'h0);
    cyc(1);
    apb_rd(5'h04, d, e);
    chk("midrst_status", d, 32'h0);
    cyc(3);
    chk("midrst_no_pulse", 32'(start_cnt), 32'(sc));

`ifdef FIR_TIMEOUT_EN
    begin
      int hits = 0;
      int at = 0;
      apb_wr(5'h10, 32'd10, e);
      apb_wr(5'h00, 32'h1, e);                  // access cycle T
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        if (FSM_abort) begin
          hits++;
          at = k;
        end
      end
      chk("tmo_pulses", 32'(hits), 32'h1);
      chk("tmo_cycle", 32'(at), 32'd12);        // WAIT_ACK at T+2, +10
      cyc(1);
      apb_rd(5'h04, d, e);
      chk("tmo_status", d, 32'h8);
      chk("tmo_abort_total", 32'(abort_cnt), 32'h1);
    end
`else
    chk("no_abort", 32'(abort_cnt), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_apb_ctrl.md
Name: fir_apb_ctrl

Overview:
APB-side control/status block for the FIR engine; sits between the APB bus and the FIR sequencing FSM.
Turns software register writes into a single-cycle START pulse and tracks the engine through pracuje/DONE.
Holds sticky status and tap/sample configuration, and raises an interrupt on completion.
Removes any need for software to clear START by hand.

Parameters:
ADDR_W, 5, APB address width (byte address, word-aligned registers)
TAP_W, 8, width of tap-count register (liczba_wsp)
SMP_W, 16, width of sample-count register (liczba_probek)
TMO_W, 24, width of timeout limit/counter (used only with FIR_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  ADDR_W  APB address
pwdata  in  32  APB write data
prdata  out  32  APB read data, registered
pready  out  1  always 1 (zero-wait slave)
pslverr  out  1  error response, valid in access phase
START  out  1  one-cycle launch pulse to FIR FSM
pracuje  in  1  FIR FSM busy
DONE  in  1  FIR FSM completion pulse (1 cycle)
liczba_wsp  out  TAP_W  configured tap count
liczba_probek  out  SMP_W  configured sample count
FSM_abort  out  1  abort pulse to FIR FSM (tied 0 without FIR_TIMEOUT_EN)
irq  out  1  level interrupt

Behaviour:
- Interface: one clock (clk); rst synchronous, active-high.
- Reset values: all outputs 0 except pready=1; liczba_wsp=1; liczba_probek=1; all status bits 0; IRQ_EN=0; state IDLE.
- APB access phase is psel&penable.
- prdata is loaded in the setup phase (psel&!penable) and is valid in the access phase.
- Writes take effect at the end of the access cycle.
- Register map:
  - 0x00 CTRL: bit0 START (write-1, self-clearing, reads 0); bit1 IRQ_EN (RW).
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, W1C); bit2 ERR (sticky, W1C); bit3 TIMEOUT (sticky, W1C).
  - 0x08 NUM_TAPS (RW, TAP_W bits).
  - 0x0C NUM_SAMPLES (RW, SMP_W bits).
  - 0x10 TMO_LIMIT (RW, macro only).
- Unmapped address: pslverr=1, read returns 0, no side effects.
- Writes to NUM_TAPS, NUM_SAMPLES or TMO_LIMIT while BUSY=1: ignored, pslverr=1.
- FSM states: IDLE, LAUNCH, WAIT_ACK, RUN.
  - IDLE: START write in cycle T with NUM_TAPS≠0 and NUM_SAMPLES≠0 → LAUNCH. START=1 during T+1 only; BUSY=1 from T+1.
  - IDLE: START write with a zero count → stay IDLE, set ERR, no pulse.
  - LAUNCH → WAIT_ACK unconditionally.
  - WAIT_ACK: pracuje=1 → RUN. DONE=1 → IDLE and set DONE (covers a very short job).
  - RUN: DONE=1 → IDLE. Set the DONE flag; BUSY=0 from next cycle.
  - START write in any state other than IDLE: ignored, ERR set, pslverr=0.
- Same-cycle W1C clear and hardware set of a flag: set wins.
- irq = DONE&IRQ_EN | ERR&IRQ_EN | TIMEOUT&IRQ_EN, driven from registers (no combinational path from inputs).
- rst mid-job: state returns to IDLE immediately and no START is issued. The FIR FSM is reset by its own reset.

Optional Feature:
FIR_TIMEOUT_EN.
- Defined:
  - TMO_LIMIT register present (reset value all 1s).
  - TMO_W cycle counter clears on entering WAIT_ACK and increments in WAIT_ACK/RUN.
  - When the counter equals TMO_LIMIT before DONE: FSM_abort pulses 1 cycle, TIMEOUT is set, state goes to IDLE.
  - A DONE arriving in the same cycle as the timeout wins: no timeout.
  - TMO_LIMIT=0 disables the timeout.
- Undefined: address 0x10 is unmapped (pslverr), STATUS bit3 reads 0, FSM_abort=0.

Decomposition:
- Package fir_ctrl_pkg holds:
  - state enum (IDLE, LAUNCH, WAIT_ACK, RUN);
  - register offset localparams;
  - STATUS/CTRL bit index constants.
- One natural sub-module, fir_apb_regs: APB decode, register storage, prdata/pslverr.
- The launch FSM and timeout counter stay in the top level.

Test Plan:
- NUM_TAPS=8, NUM_SAMPLES=4, write CTRL=0x1 at cycle T → START=1 exactly at T+1; STATUS reads 0x1 (BUSY) in the following read.
- Drive pracuje=1 at T+3 and DONE pulse at T+20 → BUSY=0, STATUS=0x2 from T+21. With IRQ_EN=1, irq=1 at T+21. W1C 0x2 → irq=0 next cycle.
- START write while RUN → no second START pulse, ERR set (STATUS bit2). Write NUM_TAPS=5 while BUSY → pslverr=1, liczba_wsp unchanged.
- NUM_TAPS=0, write START → no START pulse, ERR=1, BUSY stays 0. Read 0x14 → pslverr=1, prdata=0.
- W1C DONE in the same cycle DONE input pulses → DONE stays 1. Assert rst during RUN → next cycle STATUS=0, liczba_wsp=1, START never pulses.
- (FIR_TIMEOUT_EN) TMO_LIMIT=10, start, never assert DONE → FSM_abort pulse and TIMEOUT=1 ten cycles after WAIT_ACK entry; BUSY=0 afterwards.
